// File: rtl/peripheral_pkg.sv
// Shared register map, TCON bit positions and decode helper for the peripheral
// responder and its timer.
package peripheral_pkg;

    localparam logic [31:0] OFF_TH   = 32'h0000_0000;
    localparam logic [31:0] OFF_TL   = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON = 32'h0000_0008;
    localparam logic [31:0] OFF_LED  = 32'h0000_000C;
    localparam logic [31:0] OFF_SW   = 32'h0000_0010;
    localparam logic [31:0] OFF_DIGI = 32'h0000_0014;

    localparam int TCON_EN  = 0;
    localparam int TCON_IEN = 1;
    localparam int TCON_IRQ = 2;

    // All four digits blanked: anodes are active-low, cathodes idle high.
    localparam logic [11:0] DIGI_OFF = 12'hFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SW,
        SEL_DIGI
    } reg_sel_e;

    // Byte offset from the region base to register select; bits [1:0] are ignored.
    function automatic reg_sel_e decode_offset(input logic [31:0] offset);
        logic [31:0] word_off;
        word_off = {offset[31:2], 2'b00};
        case (word_off)
            OFF_TH:   decode_offset = SEL_TH;
            OFF_TL:   decode_offset = SEL_TL;
            OFF_TCON: decode_offset = SEL_TCON;
            OFF_LED:  decode_offset = SEL_LED;
            OFF_SW:   decode_offset = SEL_SW;
            OFF_DIGI: decode_offset = SEL_DIGI;
            default:  decode_offset = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/timer_unit.sv
// 32-bit auto-reload timer: TH reload, TL counter, TCON control/status.
// Software writes always take priority over the timer's own updates.
module timer_unit
    import peripheral_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irqout
);

    logic overflow;
    logic count_en;

    assign count_en = tcon[TCON_EN];
    assign overflow = count_en && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= 32'h0;
        end else if (th_we) begin
            th <= wdata;
        end
    end

    // On overflow TL takes the current TH, so a same-cycle TH write is seen only next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            tl <= 32'h0;
        end else if (tl_we) begin
            tl <= wdata;
        end else if (overflow) begin
            tl <= th;
        end else if (count_en) begin
            tl <= tl + 32'd1;
        end
    end

    // Status is sticky: only a software write clears it, and that write also wins over a set.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= 3'b000;
        end else if (tcon_we) begin
            tcon <= wdata[2:0];
        end else if (overflow && tcon[TCON_IEN]) begin
            tcon[TCON_IRQ] <= 1'b1;
        end
    end

    assign irqout = tcon[TCON_IRQ] & tcon[TCON_IEN];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped responder for timer, LED, switch and 7-segment registers.
// Bus: single-cycle strobes; rd returns data combinationally, wr commits on the next rising edge.
module peripheral_bus
    import peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led,
    output logic [11:0]      digi,
    output logic             irqout
);

    logic [31:0] offset;
    reg_sel_e    sel;
    logic        th_we;
    logic        tl_we;
    logic        tcon_we;
    logic        led_we;
    logic        digi_we;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;

    // Offsets past the last register (or outside the region) decode to SEL_NONE.
    assign offset  = addr - BASE_ADDR;
    assign sel     = decode_offset(offset);

    assign th_we   = wr && (sel == SEL_TH);
    assign tl_we   = wr && (sel == SEL_TL);
    assign tcon_we = wr && (sel == SEL_TCON);
    assign led_we  = wr && (sel == SEL_LED);
    assign digi_we = wr && (sel == SEL_DIGI);

    timer_unit u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (th_we),
        .tl_we   (tl_we),
        .tcon_we (tcon_we),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else if (led_we) begin
            led <= wdata[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digi <= DIGI_OFF;
        end else if (digi_we) begin
            digi <= wdata[11:0];
        end
    end

    // Register values, so a read alongside a write shows the pre-write contents.
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (sel)
                SEL_TH:   rdata = th;
                SEL_TL:   rdata = tl;
                SEL_TCON: rdata = {29'h0, tcon};
                SEL_LED:  rdata = 32'(led);
                SEL_SW:   rdata = 32'(switch);
                SEL_DIGI: rdata = {20'h0, digi};
                default:  rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: doc/peripheral_bus.md
# peripheral_bus

Memory-mapped peripheral responder at base 0x4000_0000: it serves the CPU's loads and stores to the timer, LED, switch and 7-segment registers. The timer is a 32-bit auto-reload counter that raises the CPU interrupt line. Interrupt entry is ROM word 1, and the handler saves and restores TCON around its work. The block sits beside data RAM on the CPU data bus and is selected when addr[31:28]==4'h4 decodes to this region.

## Interface

Parameters:
- BASE_ADDR, 32'h4000_0000, region base; the block responds to BASE_ADDR+0x00..0x14 only.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- addr  in  32  byte address; bits [1:0] ignored
- rd  in  1  read strobe
- wr  in  1  write strobe
- wdata  in  32  store data
- rdata  out  32  load data, combinational
- switch  in  SW_W  board switches, pre-synchronised
- led  out  LED_W  LED register
- digi  out  12  [11:8] anode select (active-low), [7:0] segment cathodes
- irqout  out  1  timer interrupt request to CPU

## Operation

- Register map (offset from BASE_ADDR):
  - 0x00 TH, reload value, R/W.
  - 0x04 TL, counter, R/W.
  - 0x08 TCON, R/W bits [2:0]: [0] enable, [1] irq enable, [2] irq status.
  - 0x0C LED, R/W, low LED_W bits.
  - 0x10 SWITCH, read-only.
  - 0x14 DIGI, R/W, low 12 bits.
- Reads return zero-extended register contents when rd=1 and the address hits the map. Otherwise rdata=0, including unmapped offsets and rd=0.
- Writes take effect on the rising clk edge when wr=1 and the address hits. Writes to SWITCH and to unmapped offsets are ignored. Unused high wdata bits are dropped.
- Timer, each cycle while TCON[0]=1:
  - TL==32'hFFFF_FFFF: TL<=TH. If TCON[1]=1, set TCON[2]<=1.
  - Otherwise TL<=TL+1, modulo 2^32.
- TCON[0]=0 freezes TL. TCON[2] is cleared only by a software write.
- irqout = TCON[2] & TCON[1]. It is level-sensitive and holds until software clears it.

## Timing

- Reset values: TH=0, TL=0, TCON=0, led=0, digi=12'hFFF (all digits off), irqout=0. rdata is combinational and follows the reset register values.
- Read latency is 0 cycles. Write latency is 1 edge, so a read in the cycle after a write returns the new value.
- Simultaneous software write to TL and timer update: the write wins.
- Simultaneous software write to TCON and an overflow status set: the write wins (the status set is lost). A write of 0 to TCON therefore guarantees irqout=0 on the next cycle.
- Overflow with TCON[1]=0: TL reloads, status is not set.
- TH written in the same cycle as an overflow: TL loads the old TH.
- Reset asserted mid-count: all registers return to reset values on that edge, and irqout drops the following cycle.
- rd and wr both asserted: the write proceeds, and rdata shows the pre-write value.

## Structure

- Shared package `peripheral_pkg`:
  - Offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI.
  - TCON bit indices: TCON_EN, TCON_IEN, TCON_IRQ.
  - DIGI_OFF reset constant.
- One sub-module, `timer_unit`, holds TH, TL and TCON, the reload and irq logic, and write-priority muxing. It exposes register write enables, read values and irqout.
- The top level holds the address decode, LED/DIGI registers and the read mux.

## Test plan

- Write TH=FFFF_0000, TL=FFFF_FFFE, TCON=3. TL reads FFFF_FFFF after 1 cycle. Reload happens on the next edge: TL reads FFFF_0000 and irqout=1.
- With irqout=1, write TCON=0. irqout=0 next cycle, and TL holds value across 10 idle cycles.
- Write TCON=1 (irq disabled) and run through an overflow. TL reloads from TH, TCON reads 1, irqout stays 0.
- Write DIGI=0x0E03 and LED=0x1A5. digi=0xE03, led=0xA5. Read of 0x14 returns 0x0000_0E03. Read of 0x18 returns 0.
- Set switch=0x5C and read 0x10, expecting 0x5C. Write 0x10 with 0xFF, then read 0x10 again, expecting 0x5C unchanged.
- Assert reset while the timer is running with irqout=1. All outputs take reset values on the next cycle, and digi=FFF.
